sample_sequencer: RTL and testbench
===================================

// Module: sample_sequencer
// PURPOSE
//  Sequences one network pass per TR/VL pulse from the epoch controller. Fetches an
//  IN_WORDS-word sample from dataset memory and streams it into the forward path.
//  Training: waits for the forward pass, then runs backprop, then pulses S_Train.
//  Validation: waits for the forward pass, then returns |err| on Error with an S_Error pulse.
// PARAMETERS
//  BITS     16    data / error width
//  ADDR     10    dataset memory address width
//  IN_WORDS 4     words per sample (>=1)
//  TIMEOUT  1023  watchdog limit in cycles (used only with SEQ_WDOG_EN)
// PORTS
//  clk         in   1     clock, rising edge
//  RST         in   1     asynchronous reset, active-high
//  TR          in   1     start training pass (1-cycle pulse)
//  VL          in   1     start validation pass (1-cycle pulse)
//  NEW_EP      in   1     zero train/valid sample indices (pulse)
//  TRAIN_BASE  in   ADDR  first address of training set
//  VALID_BASE  in   ADDR  first address of validation set
//  mem_rd      out  1     memory read strobe; data returns next cycle
//  mem_addr    out  ADDR  read address
//  mem_data    in   BITS  read data
//  x_data      out  BITS  sample word to network (=mem_data)
//  x_valid     out  1     x_data valid
//  x_last      out  1     last word of sample, qualified by x_valid
//  fwd_done    in   1     forward pass complete
//  err_in      in   BITS  signed output error, valid with fwd_done
//  bp_start    out  1     backprop launch pulse
//  bp_done     in   1     backprop complete
//  S_Train     out  1     training pass complete (1-cycle pulse)
//  S_Error     out  1     validation error ready (1-cycle pulse)
//  Error       out  BITS  unsigned |err_in|, held until next S_Error
//  BUSY        out  1     high whenever state != IDLE
//  DROP        out  1     pulse: TR/VL ignored
//  TOUT        out  1     pulse: watchdog abort (SEQ_WDOG_EN only; else tied 0)
// BEHAVIOUR
//  - RST: state IDLE; indices 0; Error 0; all outputs 0. Takes effect immediately, incl. mid-pass.
//  - States: IDLE -> FETCH -> WAIT_FWD -> (train) BACKPROP -> DONE -> IDLE;
//    (valid) WAIT_FWD -> DONE -> IDLE.
//  - IDLE: TR sampled high -> FETCH (train). Else VL high -> FETCH (valid).
//    TR & VL same cycle: train wins; DROP pulses the next cycle.
//  - FETCH: mem_rd high for exactly IN_WORDS consecutive cycles, beginning the cycle after
//    TR/VL is sampled. mem_addr = base + idx*IN_WORDS + w, w = 0..IN_WORDS-1.
//    x_valid = mem_rd delayed 1 cycle. x_last accompanies w = IN_WORDS-1.
//    Enter WAIT_FWD the cycle after the last x_valid. The sample index increments when FETCH exits.
//  - Indices are ADDR bits wide and wrap modulo 2^ADDR. Bounding the dataset is the epoch controller's job.
//  - WAIT_FWD: fwd_done is sampled only in this state; it is ignored in every other state.
//    On fwd_done: train -> bp_start pulses 1 cycle, enter BACKPROP.
//    Valid -> Error <= |err_in|, enter DONE; err_in = 0x8000 (most negative) saturates to 0x7FFF.
//  - BACKPROP: on bp_done -> DONE.
//  - DONE: 1 cycle. S_Train (train) or S_Error (valid) is high during it. Then IDLE.
//  - TR/VL while BUSY: DROP pulses 1 cycle later; no other effect.
//  - NEW_EP: clears both indices. If BUSY, the current pass completes; the clear applies to the next fetch.
//    NEW_EP with TR in the same cycle: clear first, fetch from index 0.
// CONFIGURATION
//  SEQ_WDOG_EN defined:
//    A counter runs in WAIT_FWD and BACKPROP.
//    After TIMEOUT cycles without the awaited done: TOUT pulses, state -> IDLE.
//    No S_Train/S_Error is issued, and the index stays advanced.
//  SEQ_WDOG_EN undefined: no counter; waits indefinitely; TOUT = 0.
// TESTING (IN_WORDS=4, TRAIN_BASE=0x000, VALID_BASE=0x200)
//  1 RST, TR pulse -> mem_rd 4 cycles at addr 0..3; x_valid 4 cycles, x_last on 4th;
//    fwd_done after 10 cycles -> bp_start 1 cycle; bp_done -> S_Train 1 cycle; BUSY low.
//  2 second TR -> addr 4..7; first VL -> addr 0x200..0x203.
//  3 VL, err_in=-300 -> S_Error, Error=300; VL, err_in=0x8000 -> Error=0x7FFF.
//  4 TR&VL same cycle -> train pass only, DROP once; TR during WAIT_FWD -> DROP, no fetch.
//  5 NEW_EP after 3 passes, then TR -> addr 0..3; RST during FETCH -> all outputs 0 at once.
//  6 SEQ_WDOG_EN, TIMEOUT=16, no fwd_done -> TOUT after 16 cycles, IDLE, no S_Train.
//    Without the macro -> BUSY stays high.

Source files
------------

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: memory, sample-stream and forward/backprop handshakes of the sample sequencer
//   mem_rd/mem_addr -> memory, mem_data <- memory (one cycle later)
//   x_data/x_valid/x_last -> network input stream
//   fwd_done/err_in <- forward path, bp_start -> / bp_done <- backprop engine
//   master: sequencer side, slave: environment side
interface sample_sequencer_if #(
  parameter int BITS = 16,
  parameter int ADDR = 10
);
  logic            mem_rd;
  logic [ADDR-1:0] mem_addr;
  logic [BITS-1:0] mem_data;
  logic [BITS-1:0] x_data;
  logic            x_valid;
  logic            x_last;
  logic            fwd_done;
  logic [BITS-1:0] err_in;
  logic            bp_start;
  logic            bp_done;
  modport master (
    output mem_rd, mem_addr, x_data, x_valid, x_last, bp_start,
    input  mem_data, fwd_done, err_in, bp_done
  );
  modport slave (
    input  mem_rd, mem_addr, x_data, x_valid, x_last, bp_start,
    output mem_data, fwd_done, err_in, bp_done
  );
endinterface

// File: rtl/sample_sequencer.sv
// sample_sequencer: runs one fetch/forward/(backprop) network pass per TR or VL pulse
//   clk, RST (async, active-high)
//   TR/VL start a training/validation pass, NEW_EP zeroes both sample indices
//   TRAIN_BASE/VALID_BASE dataset base addresses
//   bus: memory read, sample stream, forward/backprop handshakes (master side)
//   S_Train/S_Error pass-complete pulses, Error = |err_in| held until next S_Error
//   BUSY not idle, DROP ignored start pulse, TOUT watchdog abort
//   Optional watchdog enabled by defining SEQ_WDOG_EN
module sample_sequencer #(
  parameter int BITS     = 16,
  parameter int ADDR     = 10,
  parameter int IN_WORDS = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            TR,
  input  logic            VL,
  input  logic            NEW_EP,
  input  logic [ADDR-1:0] TRAIN_BASE,
  input  logic [ADDR-1:0] VALID_BASE,
  sample_sequencer_if.master bus,
  output logic            S_Train,
  output logic            S_Error,
  output logic [BITS-1:0] Error,
  output logic            BUSY,
  output logic            DROP,
  output logic            TOUT
);
  localparam int WW = $clog2(IN_WORDS + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_FWD, BACKPROP, DONE} state_t;
  state_t state, state_n;
  logic            train, clr, abort, start, fetch_end;
  logic [WW-1:0]   w;
  logic [ADDR-1:0] train_idx, valid_idx, cur, eff_t, eff_v;
  logic [BITS-1:0] mag;
  assign start     = state == IDLE && (TR || VL);
  assign fetch_end = state == FETCH && w == WW'(IN_WORDS);
  // a pending or same-cycle NEW_EP makes the next pass start from index 0
  assign eff_t     = (clr || NEW_EP) ? '0 : train_idx;
  assign eff_v     = (clr || NEW_EP) ? '0 : valid_idx;
  // the most negative error has no positive twin, so it saturates
  assign mag = !bus.err_in[BITS-1] ? bus.err_in :
               bus.err_in == {1'b1, {(BITS-1){1'b0}}} ? {1'b0, {(BITS-1){1'b1}}} : -bus.err_in;
  assign bus.mem_rd   = state == FETCH && w != WW'(IN_WORDS);
  assign bus.mem_addr = bus.mem_rd ? (train ? TRAIN_BASE : VALID_BASE) + ADDR'(cur * IN_WORDS) + ADDR'(w) : '0;
  assign bus.x_data   = bus.x_valid ? bus.mem_data : '0;
  assign S_Train      = state == DONE && train;
  assign S_Error      = state == DONE && !train;
  assign BUSY         = state != IDLE;
  always_ff @(posedge clk or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? FETCH : IDLE;
      FETCH:    state_n = fetch_end ? WAIT_FWD : FETCH;
      WAIT_FWD: state_n = bus.fwd_done ? (train ? BACKPROP : DONE) : WAIT_FWD;
      BACKPROP: state_n = bus.bp_done ? DONE : BACKPROP;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      train <= 1'b0;
      clr <= 1'b0;
      w <= '0;
      cur <= '0;
      train_idx <= '0;
      valid_idx <= '0;
      bus.x_valid <= 1'b0;
      bus.x_last <= 1'b0;
      bus.bp_start <= 1'b0;
      Error <= '0;
      DROP <= 1'b0;
    end else begin
      bus.x_valid <= bus.mem_rd;
      bus.x_last <= bus.mem_rd && w == WW'(IN_WORDS - 1);
      bus.bp_start <= state == WAIT_FWD && bus.fwd_done && train;
      DROP <= BUSY ? (TR || VL) : (TR && VL);
      w <= state == FETCH ? w + 1'b1 : '0;
      clr <= start ? 1'b0 : clr || NEW_EP;
      if (start) begin
        train <= TR;
        cur <= TR ? eff_t : eff_v;
        train_idx <= eff_t;
        valid_idx <= eff_v;
      end
      if (fetch_end && train) train_idx <= cur + 1'b1;
      if (fetch_end && !train) valid_idx <= cur + 1'b1;
      if (state == WAIT_FWD && bus.fwd_done && !train) Error <= mag;
    end
`ifdef SEQ_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign abort = ((state == WAIT_FWD && !bus.fwd_done) || (state == BACKPROP && !bus.bp_done)) &&
                 cnt == CW'(TIMEOUT - 1);
  // counter restarts on every state change so each wait gets a full budget
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      cnt <= '0;
      TOUT <= 1'b0;
    end else begin
      cnt <= (state_n == state && (state == WAIT_FWD || state == BACKPROP)) ? cnt + 1'b1 : '0;
      TOUT <= abort;
    end
`else
  assign abort = 1'b0;
  assign TOUT  = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: scoreboard bench for sample_sequencer (IN_WORDS=4, bases 0x000/0x200)
module tb_sample_sequencer;
  localparam int RD = 0, XD = 1, BP = 2, ST = 3, SE = 4, DR = 5, TO = 6;
  logic clk = 0, rst = 1, tr = 0, vl = 0, new_ep = 0;
  logic [9:0] train_base = 10'h000, valid_base = 10'h200;
  logic s_train, s_error, busy, drop, tout;
  logic [15:0] error;
  int tests = 0, fails = 0;
  int q [7][$];
  string nm [7] = '{"mem_addr", "x_word", "bp_start", "s_train", "s_error", "drop", "tout"};
  sample_sequencer_if #(.BITS(16), .ADDR(10)) bus ();
  sample_sequencer #(.BITS(16), .ADDR(10), .IN_WORDS(4), .TIMEOUT(16)) dut (
    .clk(clk), .RST(rst), .TR(tr), .VL(vl), .NEW_EP(new_ep),
    .TRAIN_BASE(train_base), .VALID_BASE(valid_base), .bus(bus),
    .S_Train(s_train), .S_Error(s_error), .Error(error),
    .BUSY(busy), .DROP(drop), .TOUT(tout)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] dat(input int a);
    return 16'h1000 + 16'(a);
  endfunction
  always @(posedge clk) bus.mem_data <= bus.mem_rd ? dat(int'(bus.mem_addr)) : 16'h0;
  task automatic chk(input int k, input int act);
    int e;
    tests++;
    if (q[k].size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event, got %0h", nm[k], act);
    end else begin
      e = q[k].pop_front();
      if (e != act) begin
        fails++;
        $display("FAIL %s: got %0h expected %0h", nm[k], act, e);
      end
    end
  endtask
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_rd) chk(RD, int'(bus.mem_addr));
    if (bus.x_valid) chk(XD, {15'd0, bus.x_last, bus.x_data});
    if (bus.bp_start) chk(BP, 1);
    if (s_train) chk(ST, 1);
    if (s_error) chk(SE, int'(error));
    if (drop) chk(DR, 1);
    if (tout) chk(TO, 1);
  end
  function automatic logic [50:0] outs();
    return {bus.mem_rd, bus.mem_addr, bus.x_data, bus.x_valid, bus.x_last, bus.bp_start,
            s_train, s_error, error, busy, drop, tout};
  endfunction
  task automatic push_fetch(input int a0, input int n);
    for (int i = 0; i < n; i++) begin
      q[RD].push_back(a0 + i);
      q[XD].push_back(((i == 3) ? 32'h10000 : 0) | int'(dat(a0 + i)));
    end
  endtask
  task automatic run_pass(input bit t, input bit v, input bit ep, input bit mid_tr, input bit mid_ep,
                          input int a0, input logic [15:0] err, input int e_err);
    push_fetch(a0, 4);
    if (t) begin
      q[BP].push_back(1);
      q[ST].push_back(1);
    end else q[SE].push_back(e_err);
    if (t && v) q[DR].push_back(1);
    if (mid_tr) q[DR].push_back(1);
    @(negedge clk);
    tr = t; vl = v; new_ep = ep;
    @(negedge clk);
    tr = 0; vl = 0; new_ep = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tr = mid_tr && i == 4;
      new_ep = mid_ep && i == 4;
    end
    bus.fwd_done = 1; bus.err_in = err;
    @(negedge clk);
    bus.fwd_done = 0;
    if (t) begin
      repeat (2) @(negedge clk);
      bus.bp_done = 1;
      @(negedge clk);
      bus.bp_done = 0;
    end
    repeat (2) @(negedge clk);
    check("busy_after_pass", busy, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.fwd_done = 0; bus.bp_done = 0; bus.err_in = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 0;
    @(negedge clk);
    check("idle_outputs", outs(), 0);
    run_pass(1, 0, 0, 0, 0, 'h000, 16'h0, 0);
    run_pass(1, 0, 0, 0, 0, 'h004, 16'h0, 0);
    run_pass(0, 1, 0, 0, 0, 'h200, 16'hFED4, 300);
    run_pass(0, 1, 0, 0, 0, 'h204, 16'h8000, 'h7FFF);
    run_pass(1, 1, 0, 1, 0, 'h008, 16'h0, 0);
    check("error_held", error, 16'h7FFF);
    run_pass(1, 0, 1, 0, 0, 'h000, 16'h0, 0);
    run_pass(0, 1, 0, 0, 0, 'h200, 16'h0005, 5);
    run_pass(1, 0, 0, 0, 1, 'h004, 16'h0, 0);
    run_pass(1, 0, 0, 0, 0, 'h000, 16'h0, 0);
    push_fetch('h004, 2);
    q[XD].delete(1);
    @(negedge clk);
    tr = 1;
    @(negedge clk);
    tr = 0;
    @(negedge clk);
    #2 rst = 1;
    #1 check("reset_mid_fetch", outs(), 0);
    @(negedge clk);
    rst = 0;
    run_pass(1, 0, 0, 0, 0, 'h000, 16'h0, 0);
    push_fetch('h004, 4);
`ifdef SEQ_WDOG_EN
    q[TO].push_back(1);
`endif
    @(negedge clk);
    tr = 1;
    @(negedge clk);
    tr = 0;
    repeat (40) @(negedge clk);
`ifdef SEQ_WDOG_EN
    check("busy_after_timeout", busy, 0);
`else
    check("busy_no_watchdog", busy, 1);
    check("tout_tied_low", tout, 0);
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 7; k++) check({"missing_", nm[k]}, q[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
